imem_responder: RTL and testbench
=================================

Name: imem_responder

Overview:
- Instruction-memory responder: the far end of the fetch-side memory request/response interface. The fetch unit drives this interface.
- Accepts a single-cycle request pulse (io_reqValid plus io_addr). Returns one 32-bit word after a fixed or pseudo-random latency by pulsing io_respValid with io_rdata.
- Backing store is a word array, loaded through a program-write port. Used as the simulation/FPGA instruction memory behind the fetch unit and icache. The variable-latency mode stresses the fetch unit's IDLE/WAIT handling.

Parameters:
- DEPTH, 4096, number of 32-bit words in the array (power of two).
- BASE_ADDR, 32'h8000_0000, byte address mapped to word 0.
- LATENCY, 1, fixed response latency in cycles (0 = same-cycle response); used when RAND_LAT=0.
- RAND_LAT, 0, 1 = latency drawn per request from the LFSR, range 0..MAX_LAT.
- MAX_LAT, 7, upper bound on random latency.
- LFSR_SEED, 16'hACE1, LFSR reset value (nonzero).

Ports:
- clock  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- io_reqValid  input  1  request pulse; one cycle per fetch
- io_addr  input  32  byte address of requested word
- io_respValid  output  1  response pulse; exactly one cycle per accepted request
- io_rdata  output  32  instruction word; valid only while io_respValid=1
- prog_wen  input  1  program-load write enable
- prog_addr  input  32  byte address for program write
- prog_wdata  input  32  program write data
- busy  output  1  request outstanding (state BUSY)
- proto_err  output  1  sticky error flag; cleared only by reset

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset values: io_respValid=0, io_rdata=0, busy=0, proto_err=0, state=IDLE, counter=0, LFSR=LFSR_SEED. Array contents are not reset.
- io_rdata is driven 0 whenever io_respValid=0.
- Word index = (addr - BASE_ADDR) >> 2. The address is in range iff addr >= BASE_ADDR and index < DEPTH, with 32-bit unsigned arithmetic and no wrap.
- Effective latency L:
  - RAND_LAT=0: L = LATENCY.
  - RAND_LAT=1: L = LFSR[7:0] mod (MAX_LAT+1), sampled in the accept cycle.
  - The LFSR advances once per accepted request only. It is a 16-bit Fibonacci LFSR, taps 16,14,13,11.
- States:
  - IDLE: busy=0.
    - io_reqValid=1 and L=0: io_respValid=1 combinationally in the same cycle, io_rdata=mem[idx]; remain IDLE.
    - io_reqValid=1 and L>0: latch index and range/alignment status; counter <= L-1; go to BUSY.
  - BUSY: busy=1.
    - counter != 0: counter decrements.
    - counter == 0: io_respValid=1 with io_rdata from the latched index; go to IDLE.
    - A new io_reqValid can be accepted only in IDLE; the cycle after the response is the earliest.
  - Result: a request in cycle t gets its response in cycle t+L.
- Boundary conditions:
  - io_reqValid=1 while BUSY: request dropped, proto_err <= 1, outstanding response unaffected.
  - Out-of-range address: response still issued on time with io_rdata=0; proto_err <= 1.
  - io_addr[1:0] != 0: low bits ignored for indexing; proto_err <= 1.
  - prog_wen: writes mem[prog index] at the clock edge if prog_addr is in range. Out-of-range writes are dropped, with no error.
  - Write and read to the same word in the same cycle: the read returns the old data (read-before-write).
  - prog_wen is legal in any state.
  - Reset asserted mid-BUSY: immediate return to IDLE, no response is ever issued for the lost request, array is retained.

Decomposition:
- Package imem_pkg holds:
  - typedef enum logic {IMEM_IDLE, IMEM_BUSY} imem_state;
  - LFSR tap mask constant 16'hB400;
  - function to compute word index and range.
- One sub-module, lfsr16: ports clock, reset_n, advance, seed parameter, 16-bit state output.
- Array, counter and FSM stay in imem_responder.

Test Plan:
- LATENCY=0, mem[0]=32'h0000_0013, io_reqValid with io_addr=32'h8000_0000 in cycle 5 -> io_respValid=1 and io_rdata=32'h0000_0013 in cycle 5; busy stays 0.
- LATENCY=3, program mem[1]=32'hDEAD_BEEF, request 32'h8000_0004 at cycle 10 -> busy=1 in cycles 11–13, respValid in cycle 13 only with io_rdata=32'hDEAD_BEEF, io_rdata=0 in cycles 12 and 14.
- LATENCY=3, second io_reqValid at cycle 11 -> proto_err=1 from cycle 12 on; exactly one response, in cycle 13; none follows.
- Request 32'h7FFF_FFFC, then 32'h8000_4000 (DEPTH=4096), then 32'h8000_0002 -> each gets an on-time response; io_rdata=0 for the first two, mem[0] for the third; proto_err=1.
- LATENCY=4: request at cycle 20, reset_n low at cycle 22, high at cycle 23 -> no io_respValid in cycles 20–30; busy=0 during reset; a subsequent request is served normally with preserved array data.
- RAND_LAT=1, MAX_LAT=7: 1000 back-to-back requests, each issued the cycle after the previous response -> every latency is in 0..7, all eight values occur, data matches the model, proto_err=0.

Source files
------------

// File: rtl/imem_pkg.sv
// imem_pkg: shared types and helpers for the instruction-memory responder.
//   imem_state  - responder FSM state encoding
//   LFSR_TAPS   - feedback tap mask for the 16-bit Fibonacci LFSR (taps 16,14,13,11)
//   imem_locate - byte address -> word index plus in-range flag
//   lfsr_next   - one LFSR step
package imem_pkg;

   typedef enum logic {IMEM_IDLE, IMEM_BUSY} imem_state;

   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   typedef struct packed {
      logic [31:0] idx;
      logic        in_range;
   } imem_loc;

   // The explicit addr >= base test stops addresses below the base from
   // wrapping around into the array.
   function automatic imem_loc imem_locate(input logic [31:0] addr,
                                           input logic [31:0] base,
                                           input logic [31:0] depth);
      imem_loc     loc;
      logic [31:0] offset;
      offset       = addr - base;
      loc.idx      = {2'b00, offset[31:2]};
      loc.in_range = (addr >= base) && (loc.idx < depth);
      return loc;
   endfunction

   // The feedback bit is the parity of the tapped bits.
   function automatic logic [15:0] lfsr_next(input logic [15:0] s);
      return {s[14:0], ^(s & LFSR_TAPS)};
   endfunction

endpackage

// File: rtl/imem_responder_if.sv
// imem_responder_if: fetch-side request/response bus.
//   io_reqValid  - single-cycle request pulse (master -> slave)
//   io_addr      - byte address of the requested word (master -> slave)
//   io_respValid - single-cycle response pulse (slave -> master)
//   io_rdata     - returned instruction word (slave -> master)
interface imem_responder_if;
   logic        io_reqValid;
   logic [31:0] io_addr;
   logic        io_respValid;
   logic [31:0] io_rdata;

   modport master (output io_reqValid, output io_addr,
                   input  io_respValid, input io_rdata);
   modport slave  (input  io_reqValid, input io_addr,
                   output io_respValid, output io_rdata);
endinterface

// File: rtl/lfsr16.sv
// lfsr16: 16-bit Fibonacci LFSR that steps only when asked.
//   clock   - system clock
//   reset_n - asynchronous active-low reset, loads SEED
//   advance - step the register by one position this cycle
//   state   - current register value
module lfsr16
   import imem_pkg::*;
#(
   parameter logic [15:0] SEED = 16'hACE1
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        advance,
   output logic [15:0] state
);

   logic [15:0] lfsr_r;

   // Shift register; holds its value unless advance is high.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         lfsr_r <= SEED;
      end else if (advance) begin
         lfsr_r <= lfsr_next(lfsr_r);
      end else begin
         lfsr_r <= lfsr_r;
      end
   end

   assign state = lfsr_r;

endmodule

// File: rtl/imem_responder.sv
// imem_responder: instruction memory sitting behind the fetch unit.
// Answers each accepted request with one word after a fixed or LFSR-drawn latency.
//   clock, reset_n        - clock and asynchronous active-low reset
//   io (slave)            - request/response bus from the fetch unit
//   prog_wen/addr/wdata   - program-load write port (any state)
//   busy                  - a request is outstanding
//   proto_err             - sticky: bad address, misalignment or request while busy
module imem_responder
   import imem_pkg::*;
#(
   parameter int          DEPTH     = 4096,
   parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
   parameter int          LATENCY   = 1,
   parameter int          RAND_LAT  = 0,
   parameter int          MAX_LAT   = 7,
   parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
   input  logic             clock,
   input  logic             reset_n,
   imem_responder_if.slave  io,
   input  logic             prog_wen,
   input  logic [31:0]      prog_addr,
   input  logic [31:0]      prog_wdata,
   output logic             busy,
   output logic             proto_err
);

   localparam int          AW      = $clog2(DEPTH);
   localparam logic [31:0] LAT_MOD = 32'(MAX_LAT + 1);

   logic [31:0] mem_r [DEPTH];

   imem_state   state_r, state_nx_s;
   logic [31:0] count_r, count_nx_s;
   logic [AW-1:0] idx_r;
   logic        ok_r;
   logic        proto_err_r;

   imem_loc     req_loc_s, prog_loc_s;
   logic [15:0] lfsr_s;
   logic [31:0] eff_lat_s;
   logic        accept_s, resp_s, err_s, rd_ok_s;
   logic [AW-1:0] rd_idx_s;
   logic        unused_s;

   assign req_loc_s  = imem_locate(io.io_addr, BASE_ADDR, 32'(DEPTH));
   assign prog_loc_s = imem_locate(prog_addr, BASE_ADDR, 32'(DEPTH));

   // Only the in-range part of the index and the low LFSR byte matter.
   assign unused_s = ^{req_loc_s.idx[31:AW], prog_loc_s.idx[31:AW], lfsr_s[15:8]};

   lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
      .clock   (clock),
      .reset_n (reset_n),
      .advance (accept_s),
      .state   (lfsr_s)
   );

   // Latency for a request accepted this cycle.
   always_comb begin
      eff_lat_s = 32'(LATENCY);
      if (RAND_LAT != 0) begin
         eff_lat_s = {24'd0, lfsr_s[7:0]} % LAT_MOD;
      end else begin
         eff_lat_s = 32'(LATENCY);
      end
   end

   // FSM next state, counter, response strobe and error detection.
   always_comb begin
      state_nx_s = state_r;
      count_nx_s = count_r;
      accept_s   = 1'b0;
      resp_s     = 1'b0;
      err_s      = 1'b0;
      rd_idx_s   = req_loc_s.idx[AW-1:0];
      rd_ok_s    = req_loc_s.in_range;
      case (state_r)
         IMEM_IDLE: begin
            if (io.io_reqValid) begin
               accept_s = 1'b1;
               err_s    = !req_loc_s.in_range || (io.io_addr[1:0] != 2'b00);
               if (eff_lat_s == 32'd0) begin
                  resp_s = 1'b1;
               end else begin
                  state_nx_s = IMEM_BUSY;
                  count_nx_s = eff_lat_s - 32'd1;
               end
            end else begin
               accept_s = 1'b0;
            end
         end
         IMEM_BUSY: begin
            // Data is read from the latched index at response time.
            rd_idx_s = idx_r;
            rd_ok_s  = ok_r;
            if (io.io_reqValid) begin
               err_s = 1'b1;
            end else begin
               err_s = 1'b0;
            end
            if (count_r == 32'd0) begin
               resp_s     = 1'b1;
               state_nx_s = IMEM_IDLE;
            end else begin
               count_nx_s = count_r - 32'd1;
            end
         end
         default: begin
            state_nx_s = IMEM_IDLE;
            count_nx_s = 32'd0;
         end
      endcase
   end

   // State, counter and latched request.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_r <= IMEM_IDLE;
         count_r <= 32'd0;
         idx_r   <= {AW{1'b0}};
         ok_r    <= 1'b0;
      end else begin
         state_r <= state_nx_s;
         count_r <= count_nx_s;
         if (accept_s) begin
            idx_r <= req_loc_s.idx[AW-1:0];
            ok_r  <= req_loc_s.in_range;
         end else begin
            idx_r <= idx_r;
            ok_r  <= ok_r;
         end
      end
   end

   // Sticky protocol error flag.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         proto_err_r <= 1'b0;
      end else if (err_s) begin
         proto_err_r <= 1'b1;
      end else begin
         proto_err_r <= proto_err_r;
      end
   end

   // Program-load write port; the array survives reset.
   always_ff @(posedge clock) begin
      if (prog_wen && prog_loc_s.in_range) begin
         mem_r[prog_loc_s.idx[AW-1:0]] <= prog_wdata;
      end
   end

   // Asynchronous read gives read-before-write against the port above.
   assign io.io_respValid = resp_s;
   assign io.io_rdata     = (resp_s && rd_ok_s) ? mem_r[rd_idx_s] : 32'd0;
   assign busy            = (state_r == IMEM_BUSY);
   assign proto_err       = proto_err_r;

endmodule

// File: tb/tb_imem_responder.sv
// Directed bench: four responders share clock, reset and program port.
//   0: LATENCY=0   1: LATENCY=3   2: LATENCY=4   3: RAND_LAT=1, MAX_LAT=7
module tb_imem_responder;

   localparam logic [31:0] BASE = 32'h8000_0000;

   logic        clock;
   logic        reset_n;
   logic        prog_wen;
   logic [31:0] prog_addr;
   logic [31:0] prog_wdata;
   logic [3:0]  req_valid;
   logic [31:0] req_addr [4];
   logic [3:0]  resp_valid;
   logic [31:0] rdata [4];
   logic [3:0]  busy_v;
   logic [3:0]  perr_v;

   logic [31:0] model_mem [16];
   int          n_checks;
   int          n_pass;

   for (genvar g = 0; g < 4; g++) begin : g_dut
      imem_responder_if bus ();
      assign bus.io_reqValid = req_valid[g];
      assign bus.io_addr     = req_addr[g];
      assign resp_valid[g]   = bus.io_respValid;
      assign rdata[g]        = bus.io_rdata;
      imem_responder #(
         .DEPTH     (4096),
         .BASE_ADDR (BASE),
         .LATENCY   ((g == 0) ? 0 : (g == 1) ? 3 : (g == 2) ? 4 : 1),
         .RAND_LAT  ((g == 3) ? 1 : 0),
         .MAX_LAT   (7),
         .LFSR_SEED (16'hACE1)
      ) u_dut (
         .clock      (clock),
         .reset_n    (reset_n),
         .io         (bus.slave),
         .prog_wen   (prog_wen),
         .prog_addr  (prog_addr),
         .prog_wdata (prog_wdata),
         .busy       (busy_v[g]),
         .proto_err  (perr_v[g])
      );
   end

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clock);
      #1;
   endtask

   task automatic sample();
      @(negedge clock);
   endtask

   task automatic prog(input logic [31:0] a, input logic [31:0] d);
      prog_wen   = 1'b1;
      prog_addr  = a;
      prog_wdata = d;
      next_cycle();
      prog_wen   = 1'b0;
   endtask

   task automatic reset_pulse();
      reset_n = 1'b0;
      next_cycle();
      reset_n = 1'b1;
      next_cycle();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0] d_addr [3];
      logic [31:0] d_exp [3];
      logic [15:0] lfsr_m;
      logic [7:0]  seen;
      logic [31:0] got;
      int          lat;
      int          exp_lat;
      int          ai;

      n_checks   = 0;
      n_pass     = 0;
      reset_n    = 1'b0;
      prog_wen   = 1'b0;
      prog_addr  = 32'd0;
      prog_wdata = 32'd0;
      req_valid  = 4'd0;
      for (int g = 0; g < 4; g++) req_addr[g] = 32'd0;

      // Reset values.
      repeat (3) @(posedge clock);
      #1;
      for (int g = 0; g < 4; g++) begin
         check($sformatf("rst_resp%0d", g), {31'd0, resp_valid[g]}, 32'd0);
         check($sformatf("rst_data%0d", g), rdata[g], 32'd0);
         check($sformatf("rst_busy%0d", g), {31'd0, busy_v[g]}, 32'd0);
         check($sformatf("rst_perr%0d", g), {31'd0, perr_v[g]}, 32'd0);
      end
      reset_n = 1'b1;
      next_cycle();

      // Load program; the last two writes are out of range and dropped.
      model_mem[0] = 32'h0000_0013;
      model_mem[1] = 32'hDEAD_BEEF;
      for (int i = 2; i < 16; i++) model_mem[i] = 32'hC0DE_0000 + 32'(i);
      for (int i = 0; i < 16; i++) prog(BASE + 32'(4 * i), model_mem[i]);
      prog(32'h8000_4000, 32'hBAD0_BAD0);
      prog(32'h7FFF_FFFC, 32'hBAD1_BAD1);

      // Zero latency: same-cycle response.
      req_valid[0] = 1'b1;
      req_addr[0]  = BASE;
      sample();
      check("l0_resp", {31'd0, resp_valid[0]}, 32'd1);
      check("l0_data", rdata[0], 32'h0000_0013);
      check("l0_busy", {31'd0, busy_v[0]}, 32'd0);
      next_cycle();
      req_valid[0] = 1'b0;
      sample();
      check("l0_idle_resp", {31'd0, resp_valid[0]}, 32'd0);
      check("l0_idle_data", rdata[0], 32'd0);
      check("l0_perr", {31'd0, perr_v[0]}, 32'd0);
      next_cycle();

      // Same-word read and write in one cycle returns the old word.
      req_valid[0] = 1'b1;
      req_addr[0]  = BASE + 32'd8;
      prog_wen     = 1'b1;
      prog_addr    = BASE + 32'd8;
      prog_wdata   = 32'h5555_AAAA;
      sample();
      check("rbw_old", rdata[0], model_mem[2]);
      next_cycle();
      prog_wen     = 1'b0;
      model_mem[2] = 32'h5555_AAAA;
      sample();
      check("rbw_new", rdata[0], 32'h5555_AAAA);
      next_cycle();
      req_valid[0] = 1'b0;

      // Latency 3, single request.
      for (int t = 0; t < 6; t++) begin
         req_valid[1] = (t == 0);
         req_addr[1]  = BASE + 32'd4;
         sample();
         check($sformatf("l3_resp_t%0d", t), {31'd0, resp_valid[1]}, (t == 3) ? 32'd1 : 32'd0);
         check($sformatf("l3_data_t%0d", t), rdata[1], (t == 3) ? 32'hDEAD_BEEF : 32'd0);
         check($sformatf("l3_busy_t%0d", t), {31'd0, busy_v[1]}, (t >= 1 && t <= 3) ? 32'd1 : 32'd0);
         check($sformatf("l3_perr_t%0d", t), {31'd0, perr_v[1]}, 32'd0);
         next_cycle();
      end

      // Latency 3, second request while busy is dropped and flagged.
      for (int t = 0; t < 8; t++) begin
         req_valid[1] = (t == 0 || t == 1);
         req_addr[1]  = (t == 0) ? BASE + 32'd4 : BASE + 32'd8;
         sample();
         check($sformatf("drop_resp_t%0d", t), {31'd0, resp_valid[1]}, (t == 3) ? 32'd1 : 32'd0);
         check($sformatf("drop_data_t%0d", t), rdata[1], (t == 3) ? 32'hDEAD_BEEF : 32'd0);
         check($sformatf("drop_perr_t%0d", t), {31'd0, perr_v[1]}, (t >= 2) ? 32'd1 : 32'd0);
         next_cycle();
      end

      // Out-of-range and misaligned addresses on latency 0 and 3.
      d_addr[0] = 32'h7FFF_FFFC;  d_exp[0] = 32'd0;
      d_addr[1] = 32'h8000_4000;  d_exp[1] = 32'd0;
      d_addr[2] = 32'h8000_0002;  d_exp[2] = 32'h0000_0013;
      for (int k = 0; k < 3; k++) begin
         reset_pulse();
         for (int t = 0; t < 5; t++) begin
            req_valid[0] = (t == 0);
            req_valid[1] = (t == 0);
            req_addr[0]  = d_addr[k];
            req_addr[1]  = d_addr[k];
            sample();
            if (t == 0) begin
               check($sformatf("bad%0d_l0_resp", k), {31'd0, resp_valid[0]}, 32'd1);
               check($sformatf("bad%0d_l0_data", k), rdata[0], d_exp[k]);
            end
            check($sformatf("bad%0d_l3_resp_t%0d", k, t), {31'd0, resp_valid[1]}, (t == 3) ? 32'd1 : 32'd0);
            check($sformatf("bad%0d_l3_data_t%0d", k, t), rdata[1], (t == 3) ? d_exp[k] : 32'd0);
            check($sformatf("bad%0d_l0_perr_t%0d", k, t), {31'd0, perr_v[0]}, (t >= 1) ? 32'd1 : 32'd0);
            check($sformatf("bad%0d_l3_perr_t%0d", k, t), {31'd0, perr_v[1]}, (t >= 1) ? 32'd1 : 32'd0);
            next_cycle();
         end
      end

      // Latency 4 with reset during BUSY: lost request never answered.
      reset_pulse();
      for (int t = 0; t < 17; t++) begin
         req_valid[2] = (t == 0 || t == 11);
         req_addr[2]  = BASE + 32'd4;
         if (t == 2) reset_n = 1'b0;
         if (t == 3) reset_n = 1'b1;
         sample();
         check($sformatf("rb_resp_t%0d", t), {31'd0, resp_valid[2]}, (t == 15) ? 32'd1 : 32'd0);
         check($sformatf("rb_data_t%0d", t), rdata[2], (t == 15) ? 32'hDEAD_BEEF : 32'd0);
         check($sformatf("rb_busy_t%0d", t), {31'd0, busy_v[2]},
               (t == 1 || (t >= 12 && t <= 15)) ? 32'd1 : 32'd0);
         next_cycle();
      end

      // Random latency: 1000 back-to-back requests.
      reset_pulse();
      lfsr_m = 16'hACE1;
      seen   = 8'd0;
      for (int k = 0; k < 1000; k++) begin
         ai      = k % 16;
         exp_lat = int'({24'd0, lfsr_m[7:0]} % 32'd8);
         lfsr_m  = {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
         req_valid[3] = 1'b1;
         req_addr[3]  = BASE + 32'(4 * ai);
         lat = -1;
         got = 32'd0;
         for (int t = 0; t < 10; t++) begin
            sample();
            if (lat < 0 && resp_valid[3]) begin
               lat = t;
               got = rdata[3];
            end
            next_cycle();
            req_valid[3] = 1'b0;
            if (lat >= 0) break;
         end
         check($sformatf("rnd_lat_k%0d", k), 32'(lat), 32'(exp_lat));
         check($sformatf("rnd_data_k%0d", k), got, model_mem[ai]);
         if (lat >= 0 && lat <= 7) seen[lat] = 1'b1;
      end
      check("rnd_all_lat", {24'd0, seen}, 32'h0000_00FF);
      check("rnd_perr", {31'd0, perr_v[3]}, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
